fifo_wr_framer: RTL
===================

FIFO_WR_FRAMER -- requirements
Module: fifo_wr_framer

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, the header byte emitted at the start of every frame.
REQ-002 The block SHALL have parameter MAX_LEN, default 32, the maximum payload bytes per frame (legal range 1..255).
REQ-003 The block SHALL have port clk_w  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port s_data  input  8  upstream payload byte.
REQ-006 The block SHALL have port s_valid  input  1  s_data is valid.
REQ-007 The block SHALL have port s_last  input  1  s_data is the final payload byte of the frame.
REQ-008 The block SHALL have port s_ready  output  1  the block accepts s_data this cycle.
REQ-009 The block SHALL have port buf_full  input  1  full flag from the downstream dual-clock FIFO.
REQ-010 The block SHALL have port buf_in  output  8  byte written into the FIFO.
REQ-011 The block SHALL have port wr_en  output  1  FIFO write strobe.
REQ-012 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 The block SHALL have port frame_cnt  output  8  count of completed frames, wraps 255->0.
REQ-014 The block SHALL have port err_len  output  1  one-cycle pulse on forced frame termination.

Function
REQ-015 The block SHALL implement the states IDLE, HDR, PAY and TRL.
REQ-016 IDLE: s_ready=0, wr_en=0; s_valid=1 -> HDR on the next edge; the payload byte is not consumed.
REQ-017 HDR: buf_in=SYNC_BYTE, wr_en=!buf_full; on an edge with wr_en=1 -> PAY.
REQ-018 PAY: s_ready=!buf_full, wr_en=s_valid&&!buf_full, buf_in=s_data.
REQ-019 A payload transfer SHALL occur on an edge with s_valid&&s_ready; the block then adds s_data modulo 256 to the checksum and increments the 8-bit length count.
REQ-020 On a transfer with s_last=1, PAY -> TRL.
REQ-021 On a transfer that makes the length count equal MAX_LEN with s_last=0, PAY -> TRL and err_len pulses for exactly one cycle (the cycle after that edge); later upstream bytes start a new frame.
REQ-022 TRL: buf_in=checksum, wr_en=!buf_full; on a write -> IDLE and frame_cnt increments.
REQ-023 buf_in, wr_en and s_ready SHALL be combinational from state, s_data, s_valid and buf_full, with zero latency.
REQ-024 wr_en SHALL never be 1 while buf_full=1; buf_full stalls any state with outputs held and no byte lost or duplicated.
REQ-025 Checksum and length count SHALL clear on entry to HDR.
REQ-026 Back-to-back frames: TRL -> IDLE -> HDR gives a minimum of one idle cycle between frames.

Reset
REQ-027 While rst=1 the block SHALL hold state=IDLE, checksum=0, length count=0, frame_cnt=0 and err_len=0, giving s_ready=0, wr_en=0, buf_in=0 and busy=0.
REQ-028 Assertion of rst mid-frame SHALL abort the frame immediately, with no trailer and no frame_cnt increment.
REQ-029 On the first edge after rst deasserts, the block SHALL behave as in IDLE.

Configuration
REQ-030 Macro FRAMER_CHECKSUM_EN SHALL control the checksum trailer.
REQ-031 With FRAMER_CHECKSUM_EN defined, TRL and the checksum register SHALL exist as specified above.
REQ-032 Without FRAMER_CHECKSUM_EN, the checksum logic and TRL SHALL be removed; a terminating payload write (last or MAX_LEN) SHALL go PAY -> IDLE and increment frame_cnt on that edge; err_len behaviour is unchanged.

Verification
REQ-033 Basic frame, buf_full=0: 01,02,03 with s_last on 03 -> FIFO writes A5,01,02,03,06; frame_cnt 0->1; err_len stays 0.
REQ-034 Checksum wrap: FF,02 (last) -> FIFO writes A5,FF,02,01.
REQ-035 Backpressure: buf_full=1 for 2 cycles after the first payload byte of 10,20,30 -> s_ready=0 and wr_en=0 during the stall; FIFO receives exactly A5,10,20,30,60.
REQ-036 Length limit, MAX_LEN=32: 33 bytes 00..20 with last only on 20 -> A5, 00..1F, 0xF0 checksum, err_len pulses once; byte 20 then forms a new frame A5,20,20.
REQ-037 Reset mid-frame: rst asserted after A5,01 -> wr_en=0 and busy=0 immediately; frame_cnt=0; next frame starts with A5.
REQ-038 Without FRAMER_CHECKSUM_EN: 01,02,03 (last) -> FIFO writes A5,01,02,03 only; frame_cnt=1.

Source files
------------

// File: rtl/fifo_wr_framer.sv
// Frames an upstream byte stream into a dual-clock FIFO as a sync header,
// the payload bytes and (when FRAMER_CHECKSUM_EN is defined) a checksum.
//
// Optional feature macro: FRAMER_CHECKSUM_EN
//   defined   : each frame ends with a trailer byte, the mod-256 sum of
//               its payload bytes
//   undefined : no trailer; the frame ends with its last payload byte
//
// Ports
//   clk_w     : write-domain clock, rising edge
//   rst       : asynchronous active-high reset
//   s_data    : upstream payload byte
//   s_valid   : s_data valid
//   s_last    : s_data is the final payload byte of the frame
//   s_ready   : byte accepted this cycle
//   buf_full  : downstream FIFO full
//   buf_in    : byte written into the FIFO
//   wr_en     : FIFO write strobe
//   busy      : framer is not idle
//   frame_cnt : completed frames, wraps 255->0
//   err_len   : one-cycle pulse when a frame is cut at MAX_LEN
module fifo_wr_framer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 32
) (
  input  logic       clk_w,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       buf_full,
  output logic [7:0] buf_in,
  output logic       wr_en,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic       err_len
);

  localparam logic [7:0] MaxLen = 8'(MAX_LEN);

`ifdef FRAMER_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE, HDR, PAY, TRL
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, HDR, PAY
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       err_q, err_d;
  logic       take;
  logic       term;
`ifdef FRAMER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  always_ff @(posedge clk_w or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

`ifdef FRAMER_CHECKSUM_EN
  always_ff @(posedge clk_w or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    fcnt_d  = fcnt_q;
    err_d   = 1'b0;
    s_ready = 1'b0;
    wr_en   = 1'b0;
    buf_in  = '0;
    take    = 1'b0;
    term    = 1'b0;
`ifdef FRAMER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        // The waiting byte is only a trigger; PAY consumes it.
        if (s_valid) begin
          state_d = HDR;
          len_d   = '0;
`ifdef FRAMER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      HDR: begin
        buf_in = SYNC_BYTE;
        wr_en  = !buf_full;
        if (!buf_full) state_d = PAY;
      end
      PAY: begin
        s_ready = !buf_full;
        buf_in  = s_data;
        take    = s_valid && !buf_full;
        wr_en   = take;
        if (take) begin
          len_d = len_q + 8'd1;
`ifdef FRAMER_CHECKSUM_EN
          csum_d = csum_q + s_data;
`endif
          // A frame hitting MAX_LEN without s_last is forced closed.
          term  = s_last || (len_d == MaxLen);
          if (term) begin
            err_d = !s_last;
`ifdef FRAMER_CHECKSUM_EN
            state_d = TRL;
`else
            state_d = IDLE;
            fcnt_d  = fcnt_q + 8'd1;
`endif
          end
        end
      end
`ifdef FRAMER_CHECKSUM_EN
      TRL: begin
        buf_in = csum_q;
        wr_en  = !buf_full;
        if (!buf_full) begin
          state_d = IDLE;
          fcnt_d  = fcnt_q + 8'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign frame_cnt = fcnt_q;
  assign err_len   = err_q;

endmodule
